// File: rtl/pc_ctrl_pkg.sv
// Shared types and helpers for the fetch controller: FSM states, redirect
// source encoding (numeric order is priority order) and word alignment.
package pc_ctrl_pkg;

  localparam int XLEN                = 32;
  localparam int INSTR_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  // Larger code means higher priority: trap > mret > branch > none.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_MRET   = 2'd2,
    SRC_TRAP   = 2'd3
  } redirect_src_t;

  // True when redirect source a strictly outranks source b.
  function automatic logic src_outranks(input redirect_src_t a, input redirect_src_t b);
    return logic'(a > b);
  endfunction

  // Redirect targets are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Combinational next-PC selection: picks the highest-priority redirect
// arriving this cycle, arbitrates it against any pending redirect, and
// provides the sequential successor of the current PC.
import pc_ctrl_pkg::*;

module next_pc_sel #(
  parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic [XLEN-1:0] epc,
  input  logic            pend_valid,
  input  redirect_src_t   pend_src,
  input  logic [XLEN-1:0] pend_addr,
  output logic [XLEN-1:0] seq_pc,
  output redirect_src_t   new_src,
  output logic [XLEN-1:0] new_target,
  output logic            new_misaligned,
  output logic            new_wins,
  output logic            sel_valid,
  output logic [XLEN-1:0] sel_target
);

  logic [XLEN-1:0] raw_target;
  redirect_src_t   pend_rank;

  // Fixed-priority pick among the redirect requests arriving this cycle.
  always_comb begin
    new_src    = SRC_NONE;
    raw_target = '0;
    if (trap) begin
      new_src    = SRC_TRAP;
      raw_target = trap_vector;
    end else if (mret) begin
      new_src    = SRC_MRET;
      raw_target = epc;
    end else if (branch_taken) begin
      new_src    = SRC_BRANCH;
      raw_target = branch_target;
    end
  end

  assign pend_rank      = pend_valid ? pend_src : SRC_NONE;
  assign new_target     = align_word(raw_target);
  assign new_misaligned = (new_src != SRC_NONE) && (raw_target[1:0] != 2'b00);
  // An equal-priority arrival does not replace what is already pending.
  assign new_wins       = src_outranks(new_src, pend_rank);
  assign sel_valid      = new_wins || pend_valid;
  assign sel_target     = new_wins ? new_target : pend_addr;
  assign seq_pc         = pc + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter sequencer and instruction fetch handshake. Issues one
// fetch at a time, registers the returned word and presents it downstream,
// folding in branch / trap / mret redirects that may arrive mid-fetch.
import pc_ctrl_pkg::*;

module pc_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        trap_in,
  input  logic [31:0] trap_vector_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        misaligned_out
);

  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;
  logic            req_reg;
  logic            valid_reg;
  logic            misaligned_reg;
  logic            pend_valid_reg;
  redirect_src_t   pend_src_reg;
  logic [XLEN-1:0] pend_addr_reg;

  logic [XLEN-1:0] seq_pc;
  redirect_src_t   new_src;
  logic [XLEN-1:0] new_target;
  logic            new_misaligned;
  logic            new_wins;
  logic            sel_valid;
  logic [XLEN-1:0] sel_target;

  next_pc_sel #(
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_pc_sel (
    .pc             (pc_reg),
    .branch_taken   (branch_taken_in),
    .branch_target  (branch_target_in),
    .trap           (trap_in),
    .trap_vector    (trap_vector_in),
    .mret           (mret_in),
    .epc            (epc_in),
    .pend_valid     (pend_valid_reg),
    .pend_src       (pend_src_reg),
    .pend_addr      (pend_addr_reg),
    .seq_pc         (seq_pc),
    .new_src        (new_src),
    .new_target     (new_target),
    .new_misaligned (new_misaligned),
    .new_wins       (new_wins),
    .sel_valid      (sel_valid),
    .sel_target     (sel_target)
  );

  // Fetch FSM: every output is a register so downstream sees clean levels.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= ST_RESET;
      pc_reg         <= BOOT_ADDRESS;
      instr_reg      <= '0;
      req_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_src_reg   <= SRC_NONE;
      pend_addr_reg  <= '0;
    end else begin
      misaligned_reg <= 1'b0;
      case (state_reg)
        // One idle cycle after reset; redirects here are not accepted.
        ST_RESET: begin
          state_reg <= ST_REQ;
          req_reg   <= 1'b1;
          valid_reg <= 1'b0;
        end

        // Address held until ack; redirects are collected as pending and
        // applied when the outstanding fetch completes (its data dropped).
        ST_REQ: begin
          if (imem_ack_in) begin
            if (sel_valid) begin
              pc_reg         <= sel_target;
              misaligned_reg <= new_wins && new_misaligned;
              pend_valid_reg <= 1'b0;
              pend_src_reg   <= SRC_NONE;
            end else begin
              instr_reg <= imem_rdata_in;
              state_reg <= ST_VALID;
              req_reg   <= 1'b0;
              valid_reg <= 1'b1;
            end
          end else if (new_wins) begin
            pend_valid_reg <= 1'b1;
            pend_src_reg   <= new_src;
            pend_addr_reg  <= new_target;
            misaligned_reg <= new_misaligned;
          end
        end

        // Instruction presented; a redirect drops it, stall holds it.
        ST_VALID: begin
          if (new_src != SRC_NONE) begin
            pc_reg         <= new_target;
            misaligned_reg <= new_misaligned;
            state_reg      <= ST_REQ;
            req_reg        <= 1'b1;
            valid_reg      <= 1'b0;
          end else if (!stall_in) begin
            pc_reg    <= seq_pc;
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
            valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_RESET;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out    = req_reg;
  assign imem_addr_out   = pc_reg;
  assign pc_out          = pc_reg;
  assign instr_out       = instr_reg;
  assign instr_valid_out = valid_reg;
  assign misaligned_out  = misaligned_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by a
// randomized run compared against a fetch-level reference model.
module tb_pc_fetch_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic        trap_in = 1'b0;
  logic [31:0] trap_vector_in = '0;
  logic        mret_in = 1'b0;
  logic [31:0] epc_in = '0;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid_out;
  logic        misaligned_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  pc_fetch_ctrl dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .stall_in         (stall_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .trap_in          (trap_in),
    .trap_vector_in   (trap_vector_in),
    .mret_in          (mret_in),
    .epc_in           (epc_in),
    .imem_ack_in      (imem_ack_in),
    .imem_rdata_in    (imem_rdata_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .pc_out           (pc_out),
    .instr_out        (instr_out),
    .instr_valid_out  (instr_valid_out),
    .misaligned_out   (misaligned_out)
  );

  // Reference model: phase of the current instruction (booting, being
  // fetched, being shown), its PC and word, and the best redirect seen
  // while a fetch is outstanding (rank 0 = none, 1 branch, 2 mret, 3 trap).
  localparam int P_BOOT = 0, P_FETCH = 1, P_SHOW = 2;
  int          m_phase = P_BOOT;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  bit          m_mis = 1'b0;
  int          m_pend_rank = 0;
  logic [31:0] m_pend_addr = '0;

  task automatic model_update();
    int          r;
    logic [31:0] t;
    r = 0;
    t = '0;
    if (trap_in) begin r = 3; t = trap_vector_in; end
    else if (mret_in) begin r = 2; t = epc_in; end
    else if (branch_taken_in) begin r = 1; t = branch_target_in; end
    if (rst_in) begin
      m_phase = P_BOOT; m_pc = 32'h0; m_instr = '0; m_mis = 0; m_pend_rank = 0;
    end else begin
      m_mis = 0;
      case (m_phase)
        P_BOOT: m_phase = P_FETCH;
        P_FETCH: begin
          if (r > m_pend_rank) begin
            m_pend_rank = r;
            m_pend_addr = t - (t % 4);
            m_mis = (t % 4) != 0;
          end
          if (imem_ack_in) begin
            if (m_pend_rank > 0) m_pc = m_pend_addr;
            else begin m_instr = imem_rdata_in; m_phase = P_SHOW; end
            m_pend_rank = 0;
          end
        end
        default: begin
          if (r > 0) begin
            m_pc = t - (t % 4); m_mis = (t % 4) != 0; m_phase = P_FETCH;
          end else if (!stall_in) begin
            m_pc = m_pc + 32'd4; m_phase = P_FETCH;
          end
        end
      endcase
    end
  endtask

  // Advance one clock: the model consumes the inputs seen at the edge,
  // then outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic clear_pulses();
    branch_taken_in = 0; trap_in = 0; mret_in = 0;
  endtask

  task automatic test_reset();
    rst_in = 1; step(); step();
    checks++; if (imem_req_out !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req_out); end
    checks++; if (instr_valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid_out); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000000", pc_out); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=00000000", instr_out); end
    checks++; if (misaligned_out !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b exp=0", misaligned_out); end
    rst_in = 0; step();
    checks++; if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rst_first_req got=%b/%h exp=1/00000000", imem_req_out, imem_addr_out); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_sequential();
    imem_ack_in = 1; imem_rdata_in = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({instr_valid_out, imem_req_out, pc_out, instr_out} !== {1'b1, 1'b0, 32'(i*4), 32'h13}) begin
        failures++; $display("FAIL seq_valid%0d got=%b%b/%h/%h exp=10/%h/00000013", i, instr_valid_out, imem_req_out, pc_out, instr_out, 32'(i*4)); end
      if (i < 2) begin
        step();
        checks++; if ({imem_req_out, instr_valid_out, imem_addr_out} !== {1'b1, 1'b0, 32'(i*4+4)}) begin
          failures++; $display("FAIL seq_req%0d got=%b%b/%h exp=10/%h", i, imem_req_out, instr_valid_out, imem_addr_out, 32'(i*4+4)); end
      end
    end
    $display("test_sequential done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_stall();
    imem_ack_in = 0; stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({instr_valid_out, imem_req_out, pc_out, instr_out} !== {1'b1, 1'b0, 32'h8, 32'h13}) begin
        failures++; $display("FAIL stall_hold%0d got=%b%b/%h/%h exp=10/00000008/00000013", i, instr_valid_out, imem_req_out, pc_out, instr_out); end
    end
    stall_in = 0; step();
    checks++; if ({imem_req_out, imem_addr_out} !== {1'b1, 32'hC}) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/0000000c", imem_req_out, imem_addr_out); end
    $display("test_stall done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_branch_pending();
    imem_ack_in = 1; step();
    imem_ack_in = 0; step();
    checks++; if (imem_addr_out !== 32'h10) begin failures++; $display("FAIL pend_start got=%h exp=00000010", imem_addr_out); end
    branch_taken_in = 1; branch_target_in = 32'h100; step();
    clear_pulses();
    checks++; if ({imem_req_out, instr_valid_out, imem_addr_out} !== {2'b10, 32'h10}) begin failures++; $display("FAIL pend_hold got=%b%b/%h exp=10/00000010", imem_req_out, instr_valid_out, imem_addr_out); end
    step();
    checks++; if (imem_addr_out !== 32'h10) begin failures++; $display("FAIL pend_hold2 got=%h exp=00000010", imem_addr_out); end
    imem_ack_in = 1; imem_rdata_in = 32'hDEAD_BEEF; step();
    imem_ack_in = 0;
    checks++; if ({imem_req_out, instr_valid_out, imem_addr_out} !== {2'b10, 32'h100}) begin failures++; $display("FAIL pend_apply got=%b%b/%h exp=10/00000100", imem_req_out, instr_valid_out, imem_addr_out); end
    $display("test_branch_pending done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_priority();
    imem_ack_in = 1; imem_rdata_in = 32'h13; step();
    imem_ack_in = 0;
    checks++; if ({instr_valid_out, pc_out} !== {1'b1, 32'h100}) begin failures++; $display("FAIL prio_valid got=%b/%h exp=1/00000100", instr_valid_out, pc_out); end
    trap_in = 1; trap_vector_in = 32'h200; mret_in = 1; epc_in = 32'h300;
    branch_taken_in = 1; branch_target_in = 32'h400; step();
    clear_pulses();
    checks++; if ({imem_req_out, instr_valid_out, imem_addr_out} !== {2'b10, 32'h200}) begin failures++; $display("FAIL prio_trap got=%b%b/%h exp=10/00000200", imem_req_out, instr_valid_out, imem_addr_out); end
    $display("test_priority done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_misaligned_wrap();
    imem_ack_in = 1; step();
    imem_ack_in = 0;
    branch_taken_in = 1; branch_target_in = 32'h0000_0102; step();
    clear_pulses();
    checks++; if ({imem_addr_out, misaligned_out} !== {32'h100, 1'b1}) begin failures++; $display("FAIL mis_pulse got=%h/%b exp=00000100/1", imem_addr_out, misaligned_out); end
    step();
    checks++; if (misaligned_out !== 1'b0) begin failures++; $display("FAIL mis_one_cycle got=%b exp=0", misaligned_out); end
    branch_taken_in = 1; branch_target_in = 32'hFFFF_FFFC; imem_ack_in = 1; step();
    clear_pulses();
    checks++; if ({imem_addr_out, misaligned_out, instr_valid_out} !== {32'hFFFF_FFFC, 2'b00}) begin failures++; $display("FAIL wrap_setup got=%h/%b%b exp=fffffffc/00", imem_addr_out, misaligned_out, instr_valid_out); end
    step();
    imem_ack_in = 0;
    checks++; if ({instr_valid_out, pc_out} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_valid got=%b/%h exp=1/fffffffc", instr_valid_out, pc_out); end
    step();
    checks++; if ({imem_req_out, imem_addr_out, misaligned_out} !== {1'b1, 32'h0, 1'b0}) begin failures++; $display("FAIL wrap_next got=%b/%h/%b exp=1/00000000/0", imem_req_out, imem_addr_out, misaligned_out); end
    $display("test_misaligned_wrap done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_override();
    imem_ack_in = 1; step();
    imem_ack_in = 0; step();
    checks++; if (imem_addr_out !== 32'h4) begin failures++; $display("FAIL ovr_setup got=%h exp=00000004", imem_addr_out); end
    rst_in = 1; imem_ack_in = 1; imem_rdata_in = 32'hCAFE_0001; trap_in = 1; trap_vector_in = 32'h203; step();
    rst_in = 0; imem_ack_in = 0; clear_pulses();
    checks++; if ({imem_req_out, instr_valid_out, misaligned_out, pc_out, instr_out} !== {3'b000, 32'h0, 32'h0}) begin
      failures++; $display("FAIL ovr_reset got=%b%b%b/%h/%h exp=000/00000000/00000000", imem_req_out, instr_valid_out, misaligned_out, pc_out, instr_out); end
    step();
    checks++; if ({imem_req_out, imem_addr_out} !== {1'b1, 32'h0}) begin failures++; $display("FAIL ovr_first_req got=%b/%h exp=1/00000000", imem_req_out, imem_addr_out); end
    imem_ack_in = 1; imem_rdata_in = 32'h0000_0093; step();
    imem_ack_in = 0;
    checks++; if ({instr_valid_out, pc_out, instr_out} !== {1'b1, 32'h0, 32'h93}) begin failures++; $display("FAIL ovr_no_pending got=%b/%h/%h exp=1/00000000/00000093", instr_valid_out, pc_out, instr_out); end
    $display("test_reset_override done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int n = 0; n < 3000; n++) begin
      rst_in          = ($urandom_range(0, 79) == 0);
      stall_in        = $urandom_range(0, 1) == 1;
      imem_ack_in     = $urandom_range(0, 2) != 0;
      imem_rdata_in   = $urandom;
      branch_taken_in = ($urandom_range(0, 4) == 0);
      mret_in         = ($urandom_range(0, 9) == 0);
      trap_in         = ($urandom_range(0, 11) == 0);
      t = $urandom; if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | t[3:0];
      branch_target_in = t;
      epc_in           = $urandom;
      trap_vector_in   = {$urandom_range(0, 255), 2'($urandom_range(0, 3))};
      step();
      checks++; if (imem_req_out !== (m_phase == P_FETCH)) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", n, imem_req_out, m_phase == P_FETCH); end
      checks++; if (instr_valid_out !== (m_phase == P_SHOW)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, instr_valid_out, m_phase == P_SHOW); end
      checks++; if (pc_out !== m_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, pc_out, m_pc); end
      checks++; if (imem_addr_out !== m_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, imem_addr_out, m_pc); end
      checks++; if (instr_out !== m_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", n, instr_out, m_instr); end
      checks++; if (misaligned_out !== m_mis) begin failures++; $display("FAIL rnd_mis cyc=%0d got=%b exp=%b", n, misaligned_out, m_mis); end
    end
    rst_in = 0; clear_pulses(); imem_ack_in = 0; stall_in = 0;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_pending();
    test_priority();
    test_misaligned_wrap();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
